ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 The block SHALL have parameter bitsDirect, default 6, giving the RAM address width.
REQ-002 The block SHALL have parameter sizeBitLine, default 32, giving the RAM data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port gen_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, bitsDirect bits: the request address.
REQ-009 The block SHALL have port req_wdata, input, sizeBitLine bits: the write data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: read data is available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the read data.
REQ-012 The block SHALL have port rsp_rdata, output, sizeBitLine bits: the registered read data.
REQ-013 The block SHALL have port clear_start, input, 1 bit: a pulse that requests a zero-fill of all RAM words.
REQ-014 The block SHALL have port clear_busy, output, 1 bit: a zero-fill is in progress.
REQ-015 The block SHALL have port clear_done, output, 1 bit: a one-cycle pulse when the zero-fill completes.
REQ-016 The block SHALL have port ram_we, output, 1 bit: write enable to the RAM.
REQ-017 The block SHALL have port ram_addr, output, bitsDirect bits: the RAM address.
REQ-018 The block SHALL have port ram_wdata, output, sizeBitLine bits: the RAM write data.
REQ-019 The block SHALL have port ram_rdata, input, sizeBitLine bits: the RAM's combinational read data for ram_addr.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ACCESS, RESP and CLEAR.
REQ-021 req_ready SHALL equal (state==IDLE) && !clear_start, combinationally.
REQ-022 A handshake (req_valid && req_ready) SHALL register the write flag, address and data, then move IDLE->ACCESS.
REQ-023 In ACCESS, ram_addr SHALL equal the registered address, and ram_we SHALL equal the registered write flag for exactly one cycle.
REQ-024 An ACCESS write SHALL go to IDLE and produce no response; a write accepted in cycle N is in RAM at the end of cycle N+1, and req_ready is high again in cycle N+2.
REQ-025 An ACCESS read SHALL capture ram_rdata into rsp_rdata at the end of the ACCESS cycle and go to RESP; a read accepted in cycle N gives rsp_valid=1 in cycle N+2.
REQ-026 In RESP, rsp_valid SHALL be 1, and rsp_rdata SHALL stay stable until rsp_valid && rsp_ready, which returns the FSM to IDLE.
REQ-027 clear_start in IDLE SHALL enter CLEAR and win over a simultaneous req_valid, which is not accepted in that cycle.
REQ-028 clear_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 In CLEAR, the block SHALL drive ram_we=1, ram_wdata=0 and ram_addr=counter.
REQ-030 In CLEAR, the counter SHALL run from 0 to 2**bitsDirect-1, one word per cycle, for 2**bitsDirect cycles.
REQ-031 In CLEAR, clear_busy SHALL be 1.
REQ-032 On the cycle after the last CLEAR write, clear_done SHALL be 1 for one cycle, the FSM SHALL be in IDLE, and the counter SHALL be 0 (no wrap-around beyond the last address).
REQ-033 Outside ACCESS and CLEAR, ram_we SHALL be 0, ram_addr SHALL hold its last value, and ram_wdata SHALL hold its last value.
REQ-034 req_addr and req_wdata SHALL be sampled only on a handshake; later changes SHALL NOT affect an access in flight.

Reset
REQ-035 Asserting gen_reset_n low SHALL immediately force the state to IDLE.
REQ-036 Asserting gen_reset_n low SHALL immediately force ram_we, rsp_valid, clear_busy and clear_done to 0.
REQ-037 Asserting gen_reset_n low SHALL immediately force rsp_rdata, ram_addr, ram_wdata, the clear counter and all captured request registers to 0.
REQ-038 A reset during CLEAR or RESP SHALL abort the operation, with no clear_done pulse and no response delivered.
REQ-039 req_ready SHALL be 1 in the first cycle after reset deassertion when clear_start is 0.

Verification
REQ-040 Write addr 5, data 0xDEADBEEF accepted in cycle N -> ram_we=1 and ram_addr=5 only in N+1; req_ready=1 in N+2.
REQ-041 Read addr 5 after REQ-040, rsp_ready=1 -> rsp_valid=1 in N+2 with rsp_rdata=0xDEADBEEF, then IDLE.
REQ-042 Read with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, and the request completes on the first rsp_ready=1.
REQ-043 clear_start and req_valid in the same IDLE cycle -> request not accepted; 64 cycles of ram_we=1 with addr 0..63 and data 0; clear_done one pulse; a subsequent read of addr 5 returns 0.
REQ-044 gen_reset_n low at clear counter 20 -> ram_we=0 and clear_busy=0 immediately, no clear_done, and IDLE after release.
REQ-045 clear_start pulsed during RESP -> ignored; clear_busy stays 0 and no CLEAR entry after the response.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Purpose: single-port RAM access sequencer: read/write requests plus a full zero-fill sweep.
// Latency: write lands 1 cycle after accept; read data valid 2 cycles after accept; clear takes 2**bitsDirect cycles.
// Backpressure: req_ready low outside IDLE; RESP holds rsp_rdata until rsp_ready; clear_start ignored unless IDLE.
module ram_access_ctrl #(
  parameter int bitsDirect  = 6,
  parameter int sizeBitLine = 32
) (
  input  logic                   clk,
  input  logic                   gen_reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [bitsDirect-1:0]  req_addr,
  input  logic [sizeBitLine-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [sizeBitLine-1:0] rsp_rdata,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   ram_we,
  output logic [bitsDirect-1:0]  ram_addr,
  output logic [sizeBitLine-1:0] ram_wdata,
  input  logic [sizeBitLine-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  localparam logic [bitsDirect-1:0] LAST_ADDR = '1;

  state_t                state;
  logic                  wr_q;     // captured write flag of the request in flight
  logic [bitsDirect-1:0] clr_cnt;  // zero-fill word pointer

  // A clear request takes priority over a request presented in the same cycle.
  assign req_ready = (state == IDLE) && !clear_start;

  // Main sequencer: the captured address/data live directly in ram_addr/ram_wdata,
  // which therefore hold their last value whenever the RAM is not being driven.
  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      clr_cnt    <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            ram_we     <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            clear_busy <= 1'b1;
          end else if (req_valid) begin
            state     <= ACCESS;
            wr_q      <= req_write;
            ram_we    <= req_write;
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          if (wr_q) begin
            state <= IDLE;
          end else begin
            rsp_rdata <= ram_rdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            // Last word written this cycle: stop without wrapping the pointer past the top.
            state      <= IDLE;
            ram_we     <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt  <= clr_cnt + 1'b1;
            ram_addr <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Purpose: directed bench for ram_access_ctrl with a behavioural 64x32 RAM attached.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: exercises rsp_ready stalls, clear priority and resets mid-operation.
module tb_ram_access_ctrl;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          gen_reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  ram_access_ctrl #(.bitsDirect(AW), .sizeBitLine(DW)) dut (
    .clk         (clk),
    .gen_reset_n (gen_reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, combinational read.
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Starts at the beginning of an IDLE cycle; returns at the start of cycle N+2.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  // Starts at the beginning of an IDLE cycle; returns at the start of cycle N+3.
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    smp();
    check_eq({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_dat"}, rsp_rdata, exp);
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    gen_reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; clear_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    smp();
    check_eq("rst_we",    32'(ram_we), 32'd0);
    check_eq("rst_rvld",  32'(rsp_valid), 32'd0);
    check_eq("rst_busy",  32'(clear_busy), 32'd0);
    check_eq("rst_done",  32'(clear_done), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_addr",  32'(ram_addr), 32'd0);
    check_eq("rst_wdata", ram_wdata, 32'd0);
    @(posedge clk); #1 gen_reset_n = 1'b1;
    smp();
    check_eq("rdy_after_rst", 32'(req_ready), 32'd1);

    // Write addr 5 = DEADBEEF, then disturb req_addr/req_wdata while in flight
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd5; req_wdata = 32'hDEADBEEF;
    smp();
    check_eq("wr_n_rdy", 32'(req_ready), 32'd1);
    check_eq("wr_n_we",  32'(ram_we), 32'd0);
    tick();
    req_valid = 1'b0; req_addr = 6'd9; req_wdata = 32'h0BADF00D;
    smp();
    check_eq("wr_n1_we",   32'(ram_we), 32'd1);
    check_eq("wr_n1_addr", 32'(ram_addr), 32'd5);
    check_eq("wr_n1_data", ram_wdata, 32'hDEADBEEF);
    check_eq("wr_n1_rdy",  32'(req_ready), 32'd0);
    tick();
    smp();
    check_eq("wr_n2_we",   32'(ram_we), 32'd0);
    check_eq("wr_n2_rdy",  32'(req_ready), 32'd1);
    check_eq("wr_n2_addr", 32'(ram_addr), 32'd5);
    check_eq("wr_n2_data", ram_wdata, 32'hDEADBEEF);
    check_eq("wr_mem5",    mem[5], 32'hDEADBEEF);

    // Read addr 5 with rsp_ready high
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd5; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_addr = 6'd0;
    smp();
    check_eq("rd_n1_we",   32'(ram_we), 32'd0);
    check_eq("rd_n1_addr", 32'(ram_addr), 32'd5);
    check_eq("rd_n1_vld",  32'(rsp_valid), 32'd0);
    tick();
    smp();
    check_eq("rd_n2_vld",  32'(rsp_valid), 32'd1);
    check_eq("rd_n2_dat",  rsp_rdata, 32'hDEADBEEF);
    check_eq("rd_n2_rdy",  32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    smp();
    check_eq("rd_n3_vld",  32'(rsp_valid), 32'd0);
    check_eq("rd_n3_rdy",  32'(req_ready), 32'd1);

    // Stalled read of addr 7 with a clear_start pulse while in RESP
    tick();
    do_write(6'd7, 32'h12345678);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd7; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) clear_start = 1'b1;
      smp();
      check_eq("stall_vld",  32'(rsp_valid), 32'd1);
      check_eq("stall_dat",  rsp_rdata, 32'h12345678);
      check_eq("stall_rdy",  32'(req_ready), 32'd0);
      check_eq("stall_busy", 32'(clear_busy), 32'd0);
      tick();
      clear_start = 1'b0;
    end
    rsp_ready = 1'b1;
    smp();
    check_eq("stall_rel_vld", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 1'b0;
    smp();
    check_eq("stall_end_vld",  32'(rsp_valid), 32'd0);
    check_eq("stall_end_rdy",  32'(req_ready), 32'd1);
    check_eq("stall_end_busy", 32'(clear_busy), 32'd0);
    tick();
    smp();
    check_eq("noclr_busy", 32'(clear_busy), 32'd0);
    check_eq("noclr_we",   32'(ram_we), 32'd0);

    // Preload words the clear must wipe
    tick();
    do_write(6'd3,  32'h33333333);
    do_write(6'd63, 32'h63636363);

    // Clear wins over a simultaneous write request
    clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd3; req_wdata = 32'hFFFFFFFF;
    smp();
    check_eq("clr_req_rdy", 32'(req_ready), 32'd0);
    tick();
    clear_start = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      smp();
      check_eq("clr_we",   32'(ram_we), 32'd1);
      check_eq("clr_addr", 32'(ram_addr), 32'(i));
      check_eq("clr_data", ram_wdata, 32'd0);
      check_eq("clr_busy", 32'(clear_busy), 32'd1);
      check_eq("clr_done_early", 32'(clear_done), 32'd0);
      tick();
    end
    smp();
    check_eq("clr_done",     32'(clear_done), 32'd1);
    check_eq("clr_end_we",   32'(ram_we), 32'd0);
    check_eq("clr_end_busy", 32'(clear_busy), 32'd0);
    check_eq("clr_end_rdy",  32'(req_ready), 32'd1);
    check_eq("clr_end_addr", 32'(ram_addr), 32'd63);
    tick();
    smp();
    check_eq("clr_done_pulse", 32'(clear_done), 32'd0);
    check_eq("clr_mem3",  mem[3], 32'd0);
    check_eq("clr_mem63", mem[63], 32'd0);
    tick();
    do_read("rd5_after_clr", 6'd5, 32'd0);
    do_read("rd3_after_clr", 6'd3, 32'd0);

    // Reset while the clear pointer is at 20
    do_write(6'd30, 32'h30303030);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      smp();
      if (i < 20) tick();
    end
    check_eq("abort_pre_addr", 32'(ram_addr), 32'd20);
    #1 gen_reset_n = 1'b0;
    #1;
    check_eq("abort_we",   32'(ram_we), 32'd0);
    check_eq("abort_busy", 32'(clear_busy), 32'd0);
    check_eq("abort_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1 gen_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check_eq("abort_done", 32'(clear_done), 32'd0);
      check_eq("abort_idle_we", 32'(ram_we), 32'd0);
      check_eq("abort_rdy", 32'(req_ready), 32'd1);
      tick();
    end
    do_read("rd30_survives", 6'd30, 32'h30303030);

    // Reset while a response is pending
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd30; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    smp();
    check_eq("resp_pre_vld", 32'(rsp_valid), 32'd1);
    #1 gen_reset_n = 1'b0;
    #1;
    check_eq("resp_rst_vld", 32'(rsp_valid), 32'd0);
    check_eq("resp_rst_dat", rsp_rdata, 32'd0);
    @(posedge clk); #1 gen_reset_n = 1'b1;
    rsp_ready = 1'b1;
    smp();
    check_eq("resp_post_vld", 32'(rsp_valid), 32'd0);
    check_eq("resp_post_rdy", 32'(req_ready), 32'd1);
    tick();
    smp();
    check_eq("resp_post2_vld", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
